// File: rtl/riscv_pipe_pkg.sv
// Purpose: shared types and constants for the RV32I pipeline control path.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
// Contents: hazard FSM state enum, the x0 register index, the ID/EX control
// word layout with its reset value, and the operand/destination match helper.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control fields of the ID/EX register that a bubble clears.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jalr;
  } ex_ctrl_t;

  // Value the ID/EX register loads on reset and on a bubble.
  localparam ex_ctrl_t CTRL_RESET = '0;

  // True when a source operand is actually read and names the given register.
  function automatic logic src_match(input logic       uses,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: event counter that sticks at all ones instead of wrapping.
// Latency: count_o reflects an enable on the rising edge where it is sampled.
// Backpressure: none; enable is honoured every cycle, clear wins over enable.
// Ports: clk, reset (async active-low), en_i (count this cycle),
//        clr_i (synchronous clear), count_o (registered count).
module sat_counter #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [NBits-1:0] count_o
);

  logic [NBits-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {NBits{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: load-use stall, redirect flush and memory-freeze sequencing for PC, IF/ID, ID/EX.
// Latency: control outputs are combinational from state and inputs; counters are registered.
// Backpressure: mem_busy_i freezes the front end (PC/IF/ID held, ID/EX held) until it drops.
// Ports: ID operand fields and use flags, EX load/rd, EX branch/jalr outcome, memory busy;
//        PC/IF-ID enables, IF/ID flush, ID/EX hold/bubble, stall and flush event counters.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int NBits             = 32,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1_i,
  input  logic [4:0]       if_id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_ex_mem_read_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_jalr_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_bubble_o,
  output logic [NBits-1:0] stall_count_o,
  output logic [NBits-1:0] flush_count_o
);

  // Bubbles still owed after the first one of a load-use stall.
  localparam logic [2:0] EXTRA_STALLS = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_e  state_d, state_q;
  hz_state_e  ret_d, ret_q;
  hz_state_e  eval_st;
  logic [2:0] rem_d, rem_q;

  logic hazard, redirect;
  logic pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble;
  logic stall_inc, flush_inc;

  assign hazard = id_ex_mem_read_i && (id_ex_rd_i != REG_ZERO) &&
                  (src_match(id_uses_rs1_i, if_id_rs1_i, id_ex_rd_i) ||
                   src_match(id_uses_rs2_i, if_id_rs2_i, id_ex_rd_i));

  assign redirect = ex_branch_taken_i || ex_jalr_i;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    rem_d        = rem_q;
    // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
    eval_st      = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (mem_busy_i) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
      if (state_q != MEM_WAIT) begin
        state_d = MEM_WAIT;
        ret_d   = state_q;
      end
    end else if (redirect) begin
      // Redirect also abandons any stall in progress: the stalled instruction is wrong-path.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      state_d      = RUN;
      ret_d        = RUN;
      rem_d        = '0;
    end else if (eval_st == LOAD_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      rem_d        = rem_q - 3'd1;
      state_d      = (rem_q == 3'd1) ? RUN : LOAD_STALL;
      ret_d        = RUN;
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      rem_d        = EXTRA_STALLS;
      state_d      = (EXTRA_STALLS == 3'd0) ? RUN : LOAD_STALL;
      ret_d        = RUN;
    end else begin
      state_d = RUN;
      ret_d   = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
    end
  end

  // Enables are forced low while reset is held so no register captures during reset.
  assign pc_write_o     = reset & pc_write;
  assign if_id_write_o  = reset & if_id_write;
  assign if_id_flush_o  = reset & if_id_flush;
  assign id_ex_hold_o   = reset & id_ex_hold;
  assign id_ex_bubble_o = reset & id_ex_bubble;

  sat_counter #(.NBits(NBits)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (stall_inc),
    .clr_i   (1'b0),
    .count_o (stall_count_o)
  );

  sat_counter #(.NBits(NBits)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (flush_inc),
    .clr_i   (1'b0),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: scoreboard bench for pipeline_hazard_ctrl (two configurations side by side).
// Latency: expected control outputs belong to the cycle they are pushed in.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, jr, busy;

  logic        pw_a, iw_a, fl_a, hd_a, bb_a;
  logic [3:0]  sc_a, fc_a;
  logic        pw_b, iw_b, fl_b, hd_b, bb_b;
  logic [31:0] sc_b, fc_b;

  pipeline_hazard_ctrl #(.NBits(4), .LOAD_STALL_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
    .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .id_ex_mem_read_i(mr), .id_ex_rd_i(rd),
    .ex_branch_taken_i(br), .ex_jalr_i(jr), .mem_busy_i(busy),
    .pc_write_o(pw_a), .if_id_write_o(iw_a), .if_id_flush_o(fl_a),
    .id_ex_hold_o(hd_a), .id_ex_bubble_o(bb_a),
    .stall_count_o(sc_a), .flush_count_o(fc_a)
  );

  pipeline_hazard_ctrl #(.NBits(32), .LOAD_STALL_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
    .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .id_ex_mem_read_i(mr), .id_ex_rd_i(rd),
    .ex_branch_taken_i(br), .ex_jalr_i(jr), .mem_busy_i(busy),
    .pc_write_o(pw_b), .if_id_write_o(iw_b), .if_id_flush_o(fl_b),
    .id_ex_hold_o(hd_b), .id_ex_bubble_o(bb_b),
    .stall_count_o(sc_b), .flush_count_o(fc_b)
  );

  typedef struct {
    bit     pw, iw, fl, hd, bb;
    longint sc, fc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: bubbles still owed per configuration plus event tallies.
  int     owed[2];
  longint sc_m[2];
  longint fc_m[2];
  int     lsc_m[2] = '{1, 3};
  longint max_m[2] = '{64'd15, 64'hFFFF_FFFF};

  int n_vec = 0;
  int n_bad = 0;

  task automatic model_step(input int k, output exp_t e);
    bit hz;
    e.pw = 0; e.iw = 0; e.fl = 0; e.hd = 0; e.bb = 0; e.sc = 0; e.fc = 0;
    if (!reset) begin
      owed[k] = 0;
      sc_m[k] = 0;
      fc_m[k] = 0;
    end else begin
      e.sc = sc_m[k];
      e.fc = fc_m[k];
      hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.pw = 1; e.iw = 1;
      if (busy) begin
        e.pw = 0; e.iw = 0; e.hd = 1;
      end else if (br || jr) begin
        e.fl = 1; e.bb = 1;
        owed[k] = 0;
        if (fc_m[k] < max_m[k]) fc_m[k]++;
      end else if (owed[k] > 0 || hz) begin
        e.pw = 0; e.iw = 0; e.bb = 1;
        if (sc_m[k] < max_m[k]) sc_m[k]++;
        owed[k] = (owed[k] > 0) ? owed[k] - 1 : lsc_m[k] - 1;
      end
    end
  endtask

  task automatic apply(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input bit uu1, input bit uu2,
                       input bit m, input bit b, input bit j, input bit bz);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    reset = r; rs1 = a1; rs2 = a2; rd = d; u1 = uu1; u2 = uu2;
    mr = m; br = b; jr = j; busy = bz;
    model_step(0, ea);
    model_step(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check(input string tag, input exp_t e,
                       input bit pw, input bit iw, input bit fl, input bit hd,
                       input bit bb, input longint sc, input longint fc);
    n_vec++;
    cmp({tag, ".pc_write"},     longint'(pw), longint'(e.pw));
    cmp({tag, ".if_id_write"},  longint'(iw), longint'(e.iw));
    cmp({tag, ".if_id_flush"},  longint'(fl), longint'(e.fl));
    cmp({tag, ".id_ex_hold"},   longint'(hd), longint'(e.hd));
    cmp({tag, ".id_ex_bubble"}, longint'(bb), longint'(e.bb));
    cmp({tag, ".stall_count"},  sc, e.sc);
    cmp({tag, ".flush_count"},  fc, e.fc);
  endtask

  // Monitor: the DUT presents a full control word every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a", e, pw_a, iw_a, fl_a, hd_a, bb_a, longint'(sc_a), longint'(fc_a));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b", e, pw_b, iw_b, fl_b, hd_b, bb_b, longint'(sc_b), longint'(fc_b));
    end
  end

  initial begin
    reset = 1'b0; rs1 = 5'd31; rs2 = 5'd31; rd = 5'd31;
    u1 = 1; u2 = 1; mr = 1; br = 1; jr = 1; busy = 1;

    // Reset held with every input high: everything must read zero.
    repeat (2) apply(0, 5'd31, 5'd31, 5'd31, 1, 1, 1, 1, 1, 1);
    // Release into an idle pipeline.
    repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use on rs1.
    apply(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0);
    repeat (4) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same hazard against x0, then with rs1 unused.
    apply(1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0);
    apply(1, 5'd5, 5'd0, 5'd5, 0, 0, 1, 0, 0, 0);
    // Load-use on rs2.
    apply(1, 5'd1, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0);
    repeat (4) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Hazard and taken branch together: redirect wins.
    apply(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
    apply(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0);
    repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Hazard, then memory busy for 4 cycles during the second bubble.
    apply(1, 5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 0, 0);
    repeat (4) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Hazard then reset mid-stall; no residual bubble after release.
    apply(1, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back hazards drive the 4-bit stall counter into saturation.
    repeat (20) apply(1, 5'd4, 5'd0, 5'd4, 1, 0, 1, 0, 0, 0);
    repeat (20) apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 15);
    end

    repeat (3) @(posedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
